// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU micro-sequencer.
//   alu_op_e    : op codes understood by the 4-bit accumulator ALU
//   instr_t     : one program word {last, op, operand}
//   seq_state_e : sequencer FSM states
//   NOP_INSTR   : ADD 0, which leaves the accumulator unchanged
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_OR  = 2'b10,
      OP_XOR = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic       last;
      alu_op_e    op;
      logic [3:0] operand;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DONE
   } seq_state_e;

   localparam instr_t NOP_INSTR = '{last: 1'b0, op: OP_ADD, operand: 4'd0};

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the ALU sequencer: DEPTH x instr_t register file.
//   clock, reset_L : clock and asynchronous active-low reset (clears all slots)
//   we, waddr, wdata : single write port, written at the clock edge
//   raddr, rdata     : asynchronous read port
module alu_seq_prog_mem
   import alu_seq_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset_L,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  instr_t        wdata,
   input  logic [AW-1:0] raddr,
   output instr_t        rdata
);

   instr_t mem_q [DEPTH];

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= NOP_INSTR;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read is combinational so the instruction at pc reaches the ALU in the same cycle.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving the op/operand inputs of a 4-bit accumulator ALU.
// The host loads a program, pulses start; the block optionally clears the
// accumulator, issues one instruction per cycle until the last one, then
// captures the accumulator and pulses done. A NOP (ADD 0) is driven whenever
// it is not executing, because the ALU has no enable.
//   clock, reset_L       : clock, asynchronous active-low reset
//   prog_we/addr/data    : program write port (ignored while busy)
//   start, abort         : run control
//   alu_result           : current accumulator value from the ALU
//   alu_op, alu_operand  : instruction presented to the ALU
//   busy                 : high in CLEAR and RUN
//   done                 : one-cycle pulse when result_q is updated
//   result_q             : accumulator value captured in DONE
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter  int DEPTH          = 8,
   parameter  bit CLEAR_ON_START = 1'b1,
   localparam int AW             = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset_L,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [6:0]    prog_data,
   input  logic          start,
   input  logic          abort,
   input  logic [3:0]    alu_result,
   output logic [1:0]    alu_op,
   output logic [3:0]    alu_operand,
   output logic          busy,
   output logic          done,
   output logic [3:0]    result_q
);

   seq_state_e    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [3:0]    result_d;
   instr_t        cur_instr;
   alu_op_e       op_sel;

   alu_seq_prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
      .clock   (clock),
      .reset_L (reset_L),
      .we      (prog_we && !busy),
      .waddr   (prog_addr),
      .wdata   (instr_t'(prog_data)),
      .raddr   (pc_q),
      .rdata   (cur_instr)
   );

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         result_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      result_d    = result_q;
      op_sel      = OP_ADD;
      alu_operand = 4'd0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               done     = 1'b1;
               result_d = alu_result;
               state_d  = S_IDLE;
            end
            // DONE accepts start like IDLE so runs can be issued back to back.
            if (start) begin
               pc_d    = '0;
               state_d = CLEAR_ON_START ? S_CLEAR : S_RUN;
            end
         end

         S_CLEAR: begin
            busy = 1'b1;
            // acc XOR acc = 0, without needing a reset or enable on the ALU.
            op_sel      = OP_XOR;
            alu_operand = alu_result;
            state_d     = abort ? S_IDLE : S_RUN;
         end

         S_RUN: begin
            busy        = 1'b1;
            op_sel      = cur_instr.op;
            alu_operand = cur_instr.operand;
            // Abort wins over last; the instruction driven now still executes.
            if (abort) begin
               state_d = S_IDLE;
            end else if (cur_instr.last || pc_q == AW'(DEPTH - 1)) begin
               state_d = S_DONE;
            end else begin
               pc_d = pc_q + AW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign alu_op = op_sel;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int C     = 1;

   logic          clock = 1'b0;
   logic          reset_L = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [6:0]    prog_data = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [3:0]    alu_result;
   logic [1:0]    alu_op;
   logic [3:0]    alu_operand;
   logic          busy;
   logic          done;
   logic [3:0]    result_q;

   // Accumulator ALU stand-in, with a bench-only load path to pre-set the accumulator.
   logic          acc_load = 1'b0;
   logic [3:0]    acc_load_val = 4'd0;
   logic [3:0]    acc;

   int total = 0;
   int bad   = 0;

   logic [6:0] prog_img [DEPTH];

   typedef struct {
      string            name;
      logic [7:0][6:0]  prog;
      logic [3:0]       pre;
      logic [3:0]       exp_res;
      int               exp_n;
   } vec_t;

   vec_t vecs [3];

   always #5 clock = ~clock;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L)       acc <= 4'd0;
      else if (acc_load)  acc <= acc_load_val;
      else begin
         case (alu_op)
            2'b00:   acc <= acc + alu_operand;
            2'b01:   acc <= acc - alu_operand;
            2'b10:   acc <= acc | alu_operand;
            default: acc <= acc ^ alu_operand;
         endcase
      end
   end
   assign alu_result = acc;

   alu_sequencer #(.DEPTH(DEPTH), .CLEAR_ON_START(1'b1)) dut (
      .clock       (clock),
      .reset_L     (reset_L),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .start       (start),
      .abort       (abort),
      .alu_result  (alu_result),
      .alu_op      (alu_op),
      .alu_operand (alu_operand),
      .busy        (busy),
      .done        (done),
      .result_q    (result_q)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic write_slot(input int a, input logic [6:0] d);
      @(negedge clock);
      prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
      @(negedge clock);
      prog_we = 1'b0;
      prog_img[a] = d;
   endtask

   task automatic preload(input logic [3:0] v);
      @(negedge clock);
      acc_load = 1'b1; acc_load_val = v;
      @(negedge clock);
      acc_load = 1'b0;
   endtask

   // Reference: walk the program image from slot 0, applying each op mod 16,
   // stopping after a last-flagged slot or the final slot.
   function automatic void model(output int n, output logic [3:0] r);
      int a = 0;
      n = 0;
      for (int s = 0; s < DEPTH; s++) begin
         int v = int'(prog_img[s][3:0]);
         case (prog_img[s][5:4])
            2'b00:   a = (a + v) % 16;
            2'b01:   a = (a - v + 16) % 16;
            2'b10:   a = a | v;
            default: a = a ^ v;
         endcase
         n++;
         if (prog_img[s][6]) break;
      end
      r = 4'(a);
   endfunction

   // Start a run (accumulator holds clr_opnd) and check CLEAR drive, busy length,
   // done timing and the captured result. Optionally raises abort in the DONE cycle.
   task automatic run(input string name, input logic [3:0] exp_res, input int exp_n,
                      input logic [3:0] clr_opnd, input bit abort_in_done);
      int busy_cnt = 0;
      int done_at  = 0;
      int op1 = -1, opnd1 = -1;
      @(negedge clock);
      start = 1'b1;
      for (int i = 1; i <= exp_n + C + 4; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (i == 1) begin op1 = int'(alu_op); opnd1 = int'(alu_operand); end
         if (busy) busy_cnt++;
         if (done && done_at == 0) begin
            done_at = i;
            if (abort_in_done) begin
               abort = 1'b1;
               #1 check({name, " done_with_abort"}, int'(done), 1);
            end
         end else begin
            abort = 1'b0;
         end
      end
      abort = 1'b0;
      check({name, " clear_op"}, op1, 3);
      check({name, " clear_operand"}, opnd1, int'(clr_opnd));
      check({name, " busy_cycles"}, busy_cnt, exp_n + C);
      check({name, " done_cycle"}, done_at, exp_n + C + 1);
      check({name, " result_q"}, int'(result_q), int'(exp_res));
      $display("run %s: n=%0d result_q=%0d busy=%0d done_at=%0d", name, exp_n, result_q, busy_cnt, done_at);
   endtask

   initial begin
      int n_m;
      logic [3:0] r_m, pre;
      int done_seen, second_done;

      for (int s = 0; s < DEPTH; s++) prog_img[s] = 7'h00;

      // Table: basic, wrap/all ops, implicit last.
      vecs[0].name = "basic";    vecs[0].prog = '0; vecs[0].pre = 4'd9;
      vecs[0].prog[0] = 7'h05; vecs[0].prog[1] = 7'h03; vecs[0].prog[2] = 7'h52;
      vecs[0].exp_res = 4'd6;  vecs[0].exp_n = 3;
      vecs[1].name = "wrap_ops"; vecs[1].prog = '0; vecs[1].pre = 4'd9;
      vecs[1].prog[0] = 7'h0F; vecs[1].prog[1] = 7'h03; vecs[1].prog[2] = 7'h28;
      vecs[1].prog[3] = 7'h7C;
      vecs[1].exp_res = 4'd6;  vecs[1].exp_n = 4;
      vecs[2].name = "implicit_last"; vecs[2].pre = 4'd3;
      for (int s = 0; s < 8; s++) vecs[2].prog[s] = 7'h01;
      vecs[2].exp_res = 4'd8;  vecs[2].exp_n = 8;

      // Reset state.
      repeat (2) @(negedge clock);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst result_q", int'(result_q), 0);
      check("rst alu_op", int'(alu_op), 0);
      check("rst alu_operand", int'(alu_operand), 0);
      reset_L = 1'b1;
      $display("reset released");

      for (int v = 0; v < 3; v++) begin
         for (int s = 0; s < DEPTH; s++) write_slot(s, vecs[v].prog[s]);
         preload(vecs[v].pre);
         run(vecs[v].name, vecs[v].exp_res, vecs[v].exp_n, vecs[v].pre, 1'b0);
      end

      // Protection and back-to-back: write/start while busy ignored; start in DONE.
      for (int s = 0; s < DEPTH; s++) write_slot(s, vecs[0].prog[s]);
      preload(4'd9);
      @(negedge clock);
      start = 1'b1;
      second_done = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clock);
         start = 1'b0; prog_we = 1'b0;
         if (i == 2) begin
            prog_we = 1'b1; prog_addr = 3'd0; prog_data = 7'h0F; start = 1'b1;
         end
         if (i == 5) begin
            check("b2b first_done", int'(done), 1);
            start = 1'b1;
         end
         if (i == 6) begin
            check("b2b first_result", int'(result_q), 6);
            check("b2b no_gap_busy", int'(busy), 1);
            check("b2b no_gap_clear_op", int'(alu_op), 3);
            check("b2b no_gap_clear_operand", int'(alu_operand), 6);
         end
         if (i > 6 && done && second_done == 0) second_done = i;
      end
      check("b2b second_done_cycle", second_done, 10);
      check("b2b store_unchanged_result", int'(result_q), 6);
      $display("back-to-back: second_done=%0d result_q=%0d", second_done, result_q);

      // Abort in the 2nd RUN cycle.
      write_slot(0, 7'h01); write_slot(1, 7'h01); write_slot(2, 7'h01); write_slot(3, 7'h41);
      @(negedge clock);
      start = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (i == 3) abort = 1'b1;
      end
      @(negedge clock);
      abort = 1'b0;
      check("abort busy", int'(busy), 0);
      check("abort acc", int'(acc), 2);
      check("abort alu_op", int'(alu_op), 0);
      check("abort alu_operand", int'(alu_operand), 0);
      done_seen = 0;
      repeat (6) begin
         @(negedge clock);
         if (done) done_seen++;
      end
      check("abort no_done", done_seen, 0);
      check("abort acc_hold", int'(acc), 2);
      check("abort result_q", int'(result_q), 6);
      $display("abort: acc=%0d result_q=%0d", acc, result_q);

      // Asynchronous reset mid-RUN.
      for (int s = 0; s < DEPTH; s++) write_slot(s, 7'h02);
      @(negedge clock);
      start = 1'b1;
      repeat (3) begin
         @(negedge clock);
         start = 1'b0;
      end
      #2 reset_L = 1'b0;
      #1;
      check("async_rst busy", int'(busy), 0);
      check("async_rst done", int'(done), 0);
      check("async_rst result_q", int'(result_q), 0);
      check("async_rst alu_op", int'(alu_op), 0);
      check("async_rst alu_operand", int'(alu_operand), 0);
      for (int s = 0; s < DEPTH; s++) prog_img[s] = 7'h00;
      @(negedge clock);
      reset_L = 1'b1;
      model(n_m, r_m);
      run("after_rst_zero_store", r_m, n_m, 4'd0, 1'b0);

      // Randomized programs against the reference model; abort raised in DONE.
      for (int it = 0; it < 25; it++) begin
         for (int s = 0; s < DEPTH; s++) begin
            logic [6:0] w;
            w = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            write_slot(s, w);
         end
         pre = 4'($urandom_range(0, 15));
         preload(pre);
         model(n_m, r_m);
         run($sformatf("rand%0d", it), r_m, n_m, pre, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
